// File: rtl/fpaint_pkg.sv
// Shared definitions for the paint framebuffer write path.
// Pure declarations: no logic, no latency, no flow control.
// Holds the writer state encoding and the coordinate width.
package fpaint_pkg;

    localparam int COORD_BITS = 10;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/rect_clip.sv
// Normalises two rectangle corners and clips them to the framebuffer.
// Latency: purely combinational.
// Backpressure: none; results are valid whenever the inputs are.
module rect_clip
    import fpaint_pkg::*;
#(
    parameter int WIDTH  = 100,
    parameter int HEIGHT = 100
) (
    input  logic [COORD_BITS-1:0] x0,
    input  logic [COORD_BITS-1:0] y0,
    input  logic [COORD_BITS-1:0] x1,
    input  logic [COORD_BITS-1:0] y1,
    output logic [COORD_BITS-1:0] xmin,
    output logic [COORD_BITS-1:0] xmax,
    output logic [COORD_BITS-1:0] ymin,
    output logic [COORD_BITS-1:0] ymax,
    output logic                  offscreen
);

    localparam logic [COORD_BITS-1:0] X_LAST = COORD_BITS'(WIDTH - 1);
    localparam logic [COORD_BITS-1:0] Y_LAST = COORD_BITS'(HEIGHT - 1);

    logic [COORD_BITS-1:0] x_hi;
    logic [COORD_BITS-1:0] y_hi;

    always_comb begin
        xmin = (x0 < x1) ? x0 : x1;
        x_hi = (x0 < x1) ? x1 : x0;
        ymin = (y0 < y1) ? y0 : y1;
        y_hi = (y0 < y1) ? y1 : y0;
        xmax = (x_hi > X_LAST) ? X_LAST : x_hi;
        ymax = (y_hi > Y_LAST) ? Y_LAST : y_hi;
        // Only the low corner decides visibility; the high corner is clipped.
        offscreen = (xmin > X_LAST) || (ymin > Y_LAST);
    end

endmodule

// File: rtl/rect_fill_writer.sv
// Rectangle fill engine: one framebuffer write per cycle in raster order.
// Latency: first write one cycle after accept; done coincides with the last write.
// Backpressure: cmd_ready is high only while idle; the write port is never stalled.
module rect_fill_writer
    import fpaint_pkg::*;
#(
    parameter int PALETTE_BITS = 2,
    parameter int WIDTH        = 100,
    parameter int HEIGHT       = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [COORD_BITS-1:0]   cmd_x0,
    input  logic [COORD_BITS-1:0]   cmd_y0,
    input  logic [COORD_BITS-1:0]   cmd_x1,
    input  logic [COORD_BITS-1:0]   cmd_y1,
    input  logic [PALETTE_BITS-1:0] cmd_color,
    output logic                    write_enable,
    output logic [COORD_BITS-1:0]   writeX,
    output logic [COORD_BITS-1:0]   writeY,
    output logic [PALETTE_BITS-1:0] write_color,
    output logic                    busy,
    output logic                    done
);

    state_t state_q, state_d;

    logic [COORD_BITS-1:0]   xmin_q, xmin_d;
    logic [COORD_BITS-1:0]   xmax_q, xmax_d;
    logic [COORD_BITS-1:0]   ymax_q, ymax_d;
    logic [COORD_BITS-1:0]   write_x_q, write_x_d;
    logic [COORD_BITS-1:0]   write_y_q, write_y_d;
    logic [PALETTE_BITS-1:0] write_color_q, write_color_d;
    logic                    write_enable_q, write_enable_d;
    logic                    done_q, done_d;

    logic [COORD_BITS-1:0] clip_xmin, clip_xmax, clip_ymin, clip_ymax;
    logic                  clip_offscreen;
    logic [COORD_BITS-1:0] next_x, next_y;

    rect_clip #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_clip (
        .x0        (cmd_x0),
        .y0        (cmd_y0),
        .x1        (cmd_x1),
        .y1        (cmd_y1),
        .xmin      (clip_xmin),
        .xmax      (clip_xmax),
        .ymin      (clip_ymin),
        .ymax      (clip_ymax),
        .offscreen (clip_offscreen)
    );

    // The write coordinate registers double as the fill cursor.
    always_comb begin
        state_d        = state_q;
        xmin_d         = xmin_q;
        xmax_d         = xmax_q;
        ymax_d         = ymax_q;
        write_x_d      = write_x_q;
        write_y_d      = write_y_q;
        write_color_d  = write_color_q;
        write_enable_d = 1'b0;
        done_d         = 1'b0;
        next_x         = write_x_q + 1'b1;
        next_y         = write_y_q;

        if (write_x_q == xmax_q) begin
            next_x = xmin_q;
            next_y = write_y_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (clip_offscreen) begin
                        done_d = 1'b1;
                    end else begin
                        state_d        = FILL;
                        xmin_d         = clip_xmin;
                        xmax_d         = clip_xmax;
                        ymax_d         = clip_ymax;
                        write_x_d      = clip_xmin;
                        write_y_d      = clip_ymin;
                        write_color_d  = cmd_color;
                        write_enable_d = 1'b1;
                        done_d         = (clip_xmin == clip_xmax) && (clip_ymin == clip_ymax);
                    end
                end
            end
            FILL: begin
                if ((write_x_q == xmax_q) && (write_y_q == ymax_q)) begin
                    state_d = IDLE;
                end else begin
                    write_x_d      = next_x;
                    write_y_d      = next_y;
                    write_enable_d = 1'b1;
                    done_d         = (next_x == xmax_q) && (next_y == ymax_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            xmin_q         <= '0;
            xmax_q         <= '0;
            ymax_q         <= '0;
            write_x_q      <= '0;
            write_y_q      <= '0;
            write_color_q  <= '0;
            write_enable_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            xmin_q         <= xmin_d;
            xmax_q         <= xmax_d;
            ymax_q         <= ymax_d;
            write_x_q      <= write_x_d;
            write_y_q      <= write_y_d;
            write_color_q  <= write_color_d;
            write_enable_q <= write_enable_d;
            done_q         <= done_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q == FILL);
    assign write_enable = write_enable_q;
    assign writeX       = write_x_q;
    assign writeY       = write_y_q;
    assign write_color  = write_color_q;
    assign done         = done_q;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Bench for rect_fill_writer: directed table, reset corner case and random commands
// checked against a raster-order reference model of the rectangle fill.
module tb_rect_fill_writer;

    localparam int W = 100;
    localparam int H = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [1:0] cmd_color;
    logic       write_enable;
    logic [9:0] writeX, writeY;
    logic [1:0] write_color;
    logic       busy;
    logic       done;

    rect_fill_writer #(.PALETTE_BITS(2), .WIDTH(W), .HEIGHT(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_x0       (cmd_x0),
        .cmd_y0       (cmd_y0),
        .cmd_x1       (cmd_x1),
        .cmd_y1       (cmd_y1),
        .cmd_color    (cmd_color),
        .write_enable (write_enable),
        .writeX       (writeX),
        .writeY       (writeY),
        .write_color  (write_color),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    int exp_x[$];
    int exp_y[$];
    int last_x = 0, last_y = 0, last_c = 0;
    int obs_n, obs_fx, obs_fy, obs_lx, obs_ly;

    typedef struct {
        int x0, y0, x1, y1, c;
        int n, fx, fy, lx, ly;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Every pixel inside the clipped, corner-normalised rectangle, row by row.
    function automatic void build_model(input int x0, input int y0, input int x1, input int y1);
        int lo_x, hi_x, lo_y, hi_y;
        exp_x.delete();
        exp_y.delete();
        lo_x = (x0 < x1) ? x0 : x1;
        hi_x = (x0 < x1) ? x1 : x0;
        lo_y = (y0 < y1) ? y0 : y1;
        hi_y = (y0 < y1) ? y1 : y0;
        if (hi_x > W - 1) hi_x = W - 1;
        if (hi_y > H - 1) hi_y = H - 1;
        for (int y = lo_y; y <= hi_y; y++)
            for (int x = lo_x; x <= hi_x; x++) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
    endfunction

    task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                           input int c, input bit noise);
        int waited = 0;
        int p;
        while (!cmd_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("cmd_ready_before_accept", int'(cmd_ready), 1);
        build_model(x0, y0, x1, y1);
        p = exp_x.size();
        cmd_valid = 1'b1;
        cmd_x0 = 10'(x0); cmd_y0 = 10'(y0);
        cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
        cmd_color = 2'(c);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_x0 = 10'($urandom); cmd_y0 = 10'($urandom);
        cmd_x1 = 10'($urandom); cmd_y1 = 10'($urandom);
        cmd_color = 2'($urandom);
        obs_n = 0; obs_fx = -1; obs_fy = -1; obs_lx = -1; obs_ly = -1;
        if (p == 0) begin
            chk("offscreen_done", int'(done), 1);
            chk("offscreen_we", int'(write_enable), 0);
            chk("offscreen_busy", int'(busy), 0);
            chk("offscreen_ready", int'(cmd_ready), 1);
            chk("offscreen_hold_x", int'(writeX), last_x);
            @(posedge clk); #1;
            chk("offscreen_done_clear", int'(done), 0);
        end else begin
            for (int k = 0; k < p; k++) begin
                chk("fill_we", int'(write_enable), 1);
                chk("fill_x", int'(writeX), exp_x[k]);
                chk("fill_y", int'(writeY), exp_y[k]);
                chk("fill_color", int'(write_color), c);
                chk("fill_busy", int'(busy), 1);
                chk("fill_done", int'(done), (k == p - 1) ? 1 : 0);
                if (write_enable) begin
                    if (obs_n == 0) begin obs_fx = int'(writeX); obs_fy = int'(writeY); end
                    obs_lx = int'(writeX); obs_ly = int'(writeY);
                    obs_n++;
                end
                if (noise) begin
                    cmd_valid = (k < p - 1) ? 1'($urandom) : 1'b0;
                    cmd_x0 = 10'($urandom); cmd_x1 = 10'($urandom);
                    cmd_y0 = 10'($urandom); cmd_y1 = 10'($urandom);
                    cmd_color = 2'($urandom);
                end
                @(posedge clk); #1;
            end
            chk("after_we", int'(write_enable), 0);
            chk("after_done", int'(done), 0);
            chk("after_busy", int'(busy), 0);
            chk("after_ready", int'(cmd_ready), 1);
            chk("after_hold_x", int'(writeX), exp_x[p-1]);
            chk("after_hold_y", int'(writeY), exp_y[p-1]);
            chk("after_hold_color", int'(write_color), c);
            last_x = exp_x[p-1];
            last_y = exp_y[p-1];
            last_c = c;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[9];
        tbl[0] = '{2, 3, 4, 4, 1, 6, 2, 3, 4, 4};
        tbl[1] = '{4, 4, 2, 3, 1, 6, 2, 3, 4, 4};
        tbl[2] = '{98, 99, 150, 200, 2, 2, 98, 99, 99, 99};
        tbl[3] = '{120, 5, 130, 6, 0, 0, -1, -1, -1, -1};
        tbl[4] = '{0, 0, 0, 0, 3, 1, 0, 0, 0, 0};
        tbl[5] = '{99, 99, 99, 99, 2, 1, 99, 99, 99, 99};
        tbl[6] = '{0, 0, 99, 0, 1, 100, 0, 0, 99, 0};
        tbl[7] = '{5, 200, 7, 50, 3, 150, 5, 50, 7, 99};
        tbl[8] = '{10, 100, 20, 120, 1, 0, -1, -1, -1, -1};

        rst = 1'b1; cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", int'(cmd_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_we", int'(write_enable), 0);
        chk("reset_x", int'(writeX), 0);
        chk("reset_y", int'(writeY), 0);
        chk("reset_color", int'(write_color), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].c, 1'b0);
            chk("tbl_count", obs_n, tbl[i].n);
            chk("tbl_first_x", obs_fx, tbl[i].fx);
            chk("tbl_first_y", obs_fy, tbl[i].fy);
            chk("tbl_last_x", obs_lx, tbl[i].lx);
            chk("tbl_last_y", obs_ly, tbl[i].ly);
        end

        // Reset during the third write of a 3x3 fill, with a command offered alongside.
        build_model(10, 10, 12, 12);
        cmd_valid = 1'b1;
        cmd_x0 = 10'd10; cmd_y0 = 10'd10; cmd_x1 = 10'd12; cmd_y1 = 10'd12; cmd_color = 2'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_fill_we", int'(write_enable), 1);
            chk("rst_fill_x", int'(writeX), exp_x[k]);
            chk("rst_fill_y", int'(writeY), exp_y[k]);
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
        rst = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_we", int'(write_enable), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0; cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_cmd_not_taken_busy", int'(busy), 0);
        chk("rst_cmd_not_taken_we", int'(write_enable), 0);
        last_x = 0; last_y = 0; last_c = 0;

        for (int i = 0; i < 40; i++) begin
            int ax, ay, bx, by;
            ax = $urandom_range(0, 127);
            ay = $urandom_range(0, 127);
            bx = ax + $urandom_range(0, 12);
            by = ay + $urandom_range(0, 12);
            if ($urandom_range(0, 1) == 1) run_cmd(bx, by, ax, ay, $urandom_range(0, 3), 1'b1);
            else                           run_cmd(ax, ay, bx, by, $urandom_range(0, 3), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rect_fill_writer.md
# rect_fill_writer

Command-driven pixel writer that drives the write port of the paint framebuffer: accepts one rectangle command (two corners plus palette colour) over a valid/ready handshake and emits exactly one framebuffer write per cycle, in raster order, until the rectangle is filled. Sits between the brush/UI logic and the framebuffer, so brush strokes and screen clears become single commands instead of per-pixel traffic.

## Interface
Parameters:
- PALETTE_BITS, 2, width of a palette index.
- WIDTH, 100, framebuffer width in pixels.
- HEIGHT, 100, framebuffer height in pixels.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_x0, cmd_y0  in  10 each  first corner.
- cmd_x1, cmd_y1  in  10 each  opposite corner.
- cmd_color  in  PALETTE_BITS  fill colour.
- write_enable  out  1  framebuffer write strobe.
- writeX, writeY  out  10 each  pixel being written.
- write_color  out  PALETTE_BITS  colour being written.
- busy  out  1  high while in FILL.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, FILL. Reset -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid && cmd_ready (accept cycle N), latch normalised rectangle and colour.
- Normalisation: xmin=min(x0,x1), xmax=max(x0,x1), same for y. Clip: xmax=min(xmax,WIDTH-1), ymax=min(ymax,HEIGHT-1).
- Fully off-screen (xmin>=WIDTH or ymin>=HEIGHT): accepted, no writes, stay IDLE, done=1 on cycle N+1.
- Otherwise -> FILL with cursor (cx,cy)=(xmin,ymin).
- FILL, every cycle: write_enable=1, writeX=cx, writeY=cy, write_color=latched colour. Advance: if cx==xmax then cx=xmin, cy=cy+1 else cx=cx+1.
- Last pixel (cx==xmax && cy==ymax): done=1 in that same cycle; next state IDLE.
- Inputs other than cmd_valid ignored in FILL; command fields may change freely after accept.
- Comparisons done at 10 bits, unsigned; no wrap at 1023 is possible after clipping.
- Pixel count per command = (xmax-xmin+1)*(ymax-ymin+1).

## Timing
- All outputs registered. Reset values: cmd_ready=1 (combinational from state=IDLE), busy=0, done=0, write_enable=0, writeX=0, writeY=0, write_color=0.
- Accept at cycle N -> first write on cycle N+1; last write on N+P (P = pixel count); done on N+P; cmd_ready=1 on N+P+1. Back-to-back: next command acceptable on N+P+1, its first write on N+P+2 (one idle bubble).
- Single pixel (x0==x1, y0==y1): one write on N+1 with done on N+1.
- Outside FILL, write_enable=0; writeX/writeY/write_color hold last values.
- rst mid-FILL: next cycle IDLE, write_enable=0, no done pulse; remaining pixels dropped.
- rst and cmd_valid together: command not accepted.

## Structure
- Shared package fpaint_pkg: state encoding (IDLE=0, FILL=1), COORD_BITS=10.
- Sub-module rect_clip (combinational): corner swap + clip to WIDTH/HEIGHT, outputs xmin/xmax/ymin/ymax and offscreen flag. Rest (FSM, cursor, output registers) in rect_fill_writer.

## Test plan
- Reset then accept (2,3)-(4,4), color 1 -> writes (2,3),(3,3),(4,3),(2,4),(3,4),(4,4) on cycles N+1..N+6, color 1, done at N+6, cmd_ready at N+7.
- Reversed corners (4,4)-(2,3) -> identical write sequence to previous case.
- Clip: (98,99)-(150,200), W=H=100 -> writes (98,99),(99,99) only; done at N+2.
- Off-screen (120,5)-(130,6) -> zero writes, done at N+1, cmd_ready stays 1.
- Single pixel (0,0), color 3 then immediate second command (99,99) -> writes at N+1 and N+3, two done pulses, write_enable low at N+2.
- Assert rst on third write of a 3x3 fill -> write_enable=0 next cycle, no done, busy=0, cmd_ready=1.
